// File: rtl/tty_bus.sv
// tty_bus: multi-channel memory-mapped 8N1 UART on the c2hdl core bus.
// Each channel has a TX FIFO feeding a shift engine, and an RX engine with a
// 2-flop synchroniser feeding an RX FIFO, plus sticky overrun/framing flags.
//
// Register map (channel n at BASE+8n, addr[1:0] ignored, wdata[7:0] lane):
//   +0 write TXDATA : push byte, stalls (ready=0) while TX FIFO full
//   +0 read  STATUS : {16'b0, rx_count[7:0], 3'b0, framing_err, overrun,
//                      rx_empty, tx_idle, tx_full}; completing read clears
//                      the sticky flags (a same-edge set wins)
//   +4 read  RXDATA : head byte, stalls while RX FIFO empty, pops on completion
//   +4 write        : accepted and ignored
//
// Ports: clk, rstb (async active-low), valid/write/addr/size/wdata bus request,
//   rdata/ready bus response, hit (address decode, independent of valid),
//   tx[CHANNELS] serial out (idle high), rx[CHANNELS] asynchronous serial in.
// Optional: define TTY_IRQ_EN to add irq[CHANNELS] (registered, high while a
//   channel has RX data pending or a sticky error flag set).

module tty_bus_fifo #(
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rstb,
  input  logic                   push,
  input  logic [7:0]             din,
  input  logic                   pop,
  output logic [7:0]             dout,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);
  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;

  logic [7:0]    mem_q [DEPTH];
  logic [PW-1:0] wp_q, wp_d, rp_q, rp_d;
  logic          do_push, do_pop;

  assign count = wp_q - rp_q;
  assign full  = (count == PW'(DEPTH));
  assign empty = (count == '0);
  assign dout  = mem_q[rp_q[AW-1:0]];

  // A pop on a full FIFO frees the slot the same-edge push lands in;
  // a pop on an empty FIFO is ignored, so the same-edge push survives.
  always_comb begin
    do_pop  = pop && !empty;
    do_push = push && (!full || pop);
    wp_d    = wp_q + PW'(do_push);
    rp_d    = rp_q + PW'(do_pop);
  end

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      wp_q <= '0;
      rp_q <= '0;
    end else begin
      wp_q <= wp_d;
      rp_q <= rp_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wp_q[AW-1:0]] <= din;
  end
endmodule

module tty_bus #(
  parameter int CHANNELS   = 2,
  parameter int FIFO_DEPTH = 4,
  parameter int DIV        = 16,
  parameter int BASE       = 'h3000,
  parameter int ADDR_W     = 32
) (
  input  logic                clk,
  input  logic                rstb,
  input  logic                valid,
  input  logic                write,
  input  logic [ADDR_W-1:0]   addr,
  input  logic [2:0]          size,
  input  logic [31:0]         wdata,
  output logic [31:0]         rdata,
  output logic                ready,
  output logic                hit,
  output logic [CHANNELS-1:0] tx,
  input  logic [CHANNELS-1:0] rx
`ifdef TTY_IRQ_EN
  ,
  output logic [CHANNELS-1:0] irq
`endif
);
  localparam int PW = $clog2(FIFO_DEPTH) + 1;
  localparam int CW = $clog2(DIV);

  typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_e;

  logic [ADDR_W-1:0] rel;
  logic [ADDR_W-4:0] ch_idx;
  logic              off;
  logic              unused_ok;

  logic [CHANNELS-1:0] tx_push, rx_pop, st_clr;
  logic [CHANNELS-1:0] tx_full_w, rx_empty_w;
  logic [31:0]         status_w [CHANNELS];
  logic [7:0]          head_w   [CHANNELS];

  assign rel       = addr - ADDR_W'(BASE);
  assign ch_idx    = rel[ADDR_W-1:3];
  assign off       = addr[2];
  assign hit       = (addr >= ADDR_W'(BASE)) && (rel < ADDR_W'(8 * CHANNELS));
  assign unused_ok = ^{size, wdata[31:8], rel[2:0]};

  // Bus decode: ready/rdata are combinational; side effects only on valid.
  always_comb begin
    ready   = 1'b0;
    rdata   = '0;
    tx_push = '0;
    rx_pop  = '0;
    st_clr  = '0;
    if (hit) begin
      for (int unsigned i = 0; i < CHANNELS; i++) begin
        if (ch_idx == (ADDR_W-3)'(i)) begin
          if (!off) begin
            if (write) begin
              ready      = !tx_full_w[i];
              tx_push[i] = valid && !tx_full_w[i];
            end else begin
              ready     = 1'b1;
              rdata     = status_w[i];
              st_clr[i] = valid;
            end
          end else if (!write) begin
            ready     = !rx_empty_w[i];
            rdata     = {24'b0, head_w[i]};
            rx_pop[i] = valid && !rx_empty_w[i];
          end else begin
            ready = 1'b1;
          end
        end
      end
    end
  end

  for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
    // ---------------- TX ----------------
    logic          tf_full, tf_empty, tf_pop;
    logic [7:0]    tf_head;
    logic [PW-1:0] tf_cnt_unused;

    tty_bus_fifo #(.DEPTH(FIFO_DEPTH)) u_txf (
      .clk   (clk),
      .rstb  (rstb),
      .push  (tx_push[c]),
      .din   (wdata[7:0]),
      .pop   (tf_pop),
      .dout  (tf_head),
      .full  (tf_full),
      .empty (tf_empty),
      .count (tf_cnt_unused)
    );

    state_e        ts_q, ts_d;
    logic [CW-1:0] tc_q, tc_d;
    logic [2:0]    tb_q, tb_d;
    logic [7:0]    tsh_q, tsh_d;
    logic          tx_q, tx_d;
    logic          t_last;

    assign t_last = (tc_q == CW'(DIV - 1));

    always_comb begin
      ts_d   = ts_q;
      tc_d   = tc_q;
      tb_d   = tb_q;
      tsh_d  = tsh_q;
      tx_d   = tx_q;
      tf_pop = 1'b0;
      unique case (ts_q)
        S_IDLE: begin
          if (!tf_empty) begin
            tf_pop = 1'b1;
            tsh_d  = tf_head;
            ts_d   = S_START;
            tc_d   = '0;
            tx_d   = 1'b0;
          end
        end
        S_START: begin
          if (t_last) begin
            ts_d = S_DATA;
            tc_d = '0;
            tb_d = '0;
            tx_d = tsh_q[0];
          end else begin
            tc_d = tc_q + CW'(1);
          end
        end
        S_DATA: begin
          if (t_last) begin
            tc_d = '0;
            if (tb_q == 3'd7) begin
              ts_d = S_STOP;
              tx_d = 1'b1;
            end else begin
              tb_d = tb_q + 3'd1;
              tx_d = tsh_q[tb_q + 3'd1];
            end
          end else begin
            tc_d = tc_q + CW'(1);
          end
        end
        default: begin // S_STOP: reload straight into START for gap-free frames
          if (t_last) begin
            tc_d = '0;
            if (!tf_empty) begin
              tf_pop = 1'b1;
              tsh_d  = tf_head;
              ts_d   = S_START;
              tx_d   = 1'b0;
            end else begin
              ts_d = S_IDLE;
            end
          end else begin
            tc_d = tc_q + CW'(1);
          end
        end
      endcase
    end

    always_ff @(posedge clk or negedge rstb) begin
      if (!rstb) begin
        ts_q  <= S_IDLE;
        tc_q  <= '0;
        tb_q  <= '0;
        tsh_q <= '0;
        tx_q  <= 1'b1;
      end else begin
        ts_q  <= ts_d;
        tc_q  <= tc_d;
        tb_q  <= tb_d;
        tsh_q <= tsh_d;
        tx_q  <= tx_d;
      end
    end

    assign tx[c]        = tx_q;
    assign tx_full_w[c] = tf_full;

    // ---------------- RX ----------------
    logic          rf_full, rf_empty, rf_push;
    logic [7:0]    rf_head;
    logic [PW-1:0] rf_cnt;

    state_e        rs_q, rs_d;
    logic [CW-1:0] rc_q, rc_d;
    logic [2:0]    rb_q, rb_d;
    logic [7:0]    rsh_q, rsh_d;
    logic          rs1_q, rs2_q, rp_q;
    logic          ovr_q, ovr_d, fe_q, fe_d;
    logic          ovr_set, fe_set;
    logic          r_last;

    tty_bus_fifo #(.DEPTH(FIFO_DEPTH)) u_rxf (
      .clk   (clk),
      .rstb  (rstb),
      .push  (rf_push),
      .din   (rsh_q),
      .pop   (rx_pop[c]),
      .dout  (rf_head),
      .full  (rf_full),
      .empty (rf_empty),
      .count (rf_cnt)
    );

    assign r_last = (rc_q == CW'(DIV - 1));

    always_comb begin
      rs_d    = rs_q;
      rc_d    = rc_q;
      rb_d    = rb_q;
      rsh_d   = rsh_q;
      rf_push = 1'b0;
      ovr_set = 1'b0;
      fe_set  = 1'b0;
      unique case (rs_q)
        S_IDLE: begin
          rc_d = '0;
          // falling edge on the synchronised line
          if (rp_q && !rs2_q) rs_d = S_START;
        end
        S_START: begin
          if (rc_q == CW'(DIV / 2 - 1)) begin
            rc_d = '0;
            rb_d = '0;
            rs_d = rs2_q ? S_IDLE : S_DATA;
          end else begin
            rc_d = rc_q + CW'(1);
          end
        end
        S_DATA: begin
          if (r_last) begin
            rc_d  = '0;
            rsh_d = {rs2_q, rsh_q[7:1]};
            rb_d  = rb_q + 3'd1;
            if (rb_q == 3'd7) rs_d = S_STOP;
          end else begin
            rc_d = rc_q + CW'(1);
          end
        end
        default: begin // S_STOP
          if (r_last) begin
            rc_d = '0;
            rs_d = S_IDLE;
            if (!rs2_q)       fe_set  = 1'b1;
            else if (rf_full) ovr_set = 1'b1;
            else              rf_push = 1'b1;
          end else begin
            rc_d = rc_q + CW'(1);
          end
        end
      endcase
      ovr_d = ovr_set || (ovr_q && !st_clr[c]);
      fe_d  = fe_set  || (fe_q  && !st_clr[c]);
    end

    always_ff @(posedge clk or negedge rstb) begin
      if (!rstb) begin
        rs1_q <= 1'b1;
        rs2_q <= 1'b1;
        rp_q  <= 1'b1;
        rs_q  <= S_IDLE;
        rc_q  <= '0;
        rb_q  <= '0;
        rsh_q <= '0;
        ovr_q <= 1'b0;
        fe_q  <= 1'b0;
      end else begin
        rs1_q <= rx[c];
        rs2_q <= rs1_q;
        rp_q  <= rs2_q;
        rs_q  <= rs_d;
        rc_q  <= rc_d;
        rb_q  <= rb_d;
        rsh_q <= rsh_d;
        ovr_q <= ovr_d;
        fe_q  <= fe_d;
      end
    end

    assign rx_empty_w[c] = rf_empty;
    assign head_w[c]     = rf_head;
    assign status_w[c]   = {16'b0, 8'(rf_cnt), 3'b0, fe_q, ovr_q, rf_empty,
                            (tf_empty && (ts_q == S_IDLE)), tf_full};

`ifdef TTY_IRQ_EN
    logic irq_q, irq_d;
    assign irq_d = !rf_empty || ovr_q || fe_q;
    always_ff @(posedge clk or negedge rstb) begin
      if (!rstb) irq_q <= 1'b0;
      else       irq_q <= irq_d;
    end
    assign irq[c] = irq_q;
`endif
  end
endmodule

// File: tb/tb_tty_bus.sv
module tb_tty_bus;
  localparam int CH = 2;

  logic          clk   = 1'b0;
  logic          rstb  = 1'b0;
  logic          valid = 1'b0;
  logic          write = 1'b0;
  logic [31:0]   addr  = '0;
  logic [2:0]    size  = '0;
  logic [31:0]   wdata = '0;
  logic [31:0]   rdata;
  logic          ready;
  logic          hit;
  logic [CH-1:0] tx;
  logic [CH-1:0] rx = '1;
`ifdef TTY_IRQ_EN
  logic [CH-1:0] irq;
`endif

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  tty_bus #(
    .CHANNELS  (CH),
    .FIFO_DEPTH(4),
    .DIV       (16),
    .BASE      ('h3000),
    .ADDR_W    (32)
  ) dut (
    .clk  (clk),
    .rstb (rstb),
    .valid(valid),
    .write(write),
    .addr (addr),
    .size (size),
    .wdata(wdata),
    .rdata(rdata),
    .ready(ready),
    .hit  (hit),
    .tx   (tx),
    .rx   (rx)
`ifdef TTY_IRQ_EN
    ,
    .irq  (irq)
`endif
  );

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 'h%0h, expected 'h%0h", nm, act, exp);
    end
  endtask

  // Called at a negedge; returns at the negedge after the completing posedge.
  task automatic bus_xfer(input logic wr, input logic [31:0] a, input logic [31:0] wd,
                          input int max_cyc, output logic [31:0] rd, output int cyc,
                          output bit ok);
    valid = 1'b1; write = wr; addr = a; wdata = wd; size = 3'($urandom_range(0, 7));
    cyc = 0; ok = 1'b0; rd = '0;
    while (cyc < max_cyc) begin
      #1;
      if (ready) begin
        rd = rdata; ok = 1'b1;
        @(posedge clk);
        break;
      end
      @(negedge clk);
      cyc++;
    end
    if (ok) @(negedge clk);
    valid = 1'b0; write = 1'b0;
  endtask

  task automatic send_rx(input int ch, input logic [7:0] b, input logic stp);
    logic [9:0] f;
    f = {stp, b, 1'b0};
    for (int i = 0; i < 10; i++) begin
      rx[ch] = f[i];
      repeat (16) @(negedge clk);
    end
    rx[ch] = 1'b1;
  endtask

  // Samples each of n frames at mid-bit; frames carry b0, b0+1, ... with no gap.
  task automatic tx_mon(input int ch, input int n, input logic [7:0] b0);
    int w;
    logic [9:0] act;
    w = 0;
    while (tx[ch] !== 1'b0 && w < 50) begin
      @(negedge clk);
      w++;
    end
    check("tx_start_seen", 32'(w < 50), 1);
    if (w >= 50) return;
    repeat (8) @(negedge clk);
    for (int f = 0; f < n; f++) begin
      for (int b = 0; b < 10; b++) begin
        act[b] = tx[ch];
        repeat (16) @(negedge clk);
      end
      check($sformatf("tx%0d_frame%0d", ch, f), {22'b0, act}, {22'b0, 1'b1, 8'(b0 + 8'(f)), 1'b0});
    end
    check("tx_idle_after", 32'(tx[ch]), 1);
  endtask

  typedef struct packed {
    logic [31:0] a;
    logic        wr;
    logic        e_hit;
    logic        e_rdy;
    logic        chk_rd;
    logic [31:0] e_rd;
  } vec_t;

  vec_t vecs[11];

  initial begin
    logic [31:0] rd;
    int          cyc;
    bit          ok;

    vecs[0]  = '{a: 32'h3000, wr: 1'b0, e_hit: 1'b1, e_rdy: 1'b1, chk_rd: 1'b1, e_rd: 32'h6};
    vecs[1]  = '{a: 32'h3000, wr: 1'b1, e_hit: 1'b1, e_rdy: 1'b1, chk_rd: 1'b1, e_rd: 32'h0};
    vecs[2]  = '{a: 32'h3004, wr: 1'b0, e_hit: 1'b1, e_rdy: 1'b0, chk_rd: 1'b0, e_rd: 32'h0};
    vecs[3]  = '{a: 32'h3004, wr: 1'b1, e_hit: 1'b1, e_rdy: 1'b1, chk_rd: 1'b1, e_rd: 32'h0};
    vecs[4]  = '{a: 32'h3008, wr: 1'b0, e_hit: 1'b1, e_rdy: 1'b1, chk_rd: 1'b1, e_rd: 32'h6};
    vecs[5]  = '{a: 32'h300C, wr: 1'b0, e_hit: 1'b1, e_rdy: 1'b0, chk_rd: 1'b0, e_rd: 32'h0};
    vecs[6]  = '{a: 32'h300F, wr: 1'b0, e_hit: 1'b1, e_rdy: 1'b0, chk_rd: 1'b0, e_rd: 32'h0};
    vecs[7]  = '{a: 32'h3003, wr: 1'b0, e_hit: 1'b1, e_rdy: 1'b1, chk_rd: 1'b1, e_rd: 32'h6};
    vecs[8]  = '{a: 32'h3010, wr: 1'b0, e_hit: 1'b0, e_rdy: 1'b0, chk_rd: 1'b1, e_rd: 32'h0};
    vecs[9]  = '{a: 32'h2FFF, wr: 1'b0, e_hit: 1'b0, e_rdy: 1'b0, chk_rd: 1'b1, e_rd: 32'h0};
    vecs[10] = '{a: 32'h0000, wr: 1'b1, e_hit: 1'b0, e_rdy: 1'b0, chk_rd: 1'b1, e_rd: 32'h0};

    // reset
    repeat (3) @(negedge clk);
    check("rst_tx", 32'(tx), 32'h3);
    rstb = 1'b1;
    @(negedge clk);

    // decode table, valid=0 so nothing has side effects
    for (int i = 0; i < 11; i++) begin
      addr = vecs[i].a; write = vecs[i].wr; wdata = 32'hA5; valid = 1'b0;
      #1;
      check($sformatf("vec%0d_hit", i), 32'(hit), 32'(vecs[i].e_hit));
      check($sformatf("vec%0d_ready", i), 32'(ready), 32'(vecs[i].e_rdy));
      if (vecs[i].chk_rd) check($sformatf("vec%0d_rdata", i), rdata, vecs[i].e_rd);
      @(negedge clk);
    end
    write = 1'b0; addr = '0;

    // single TX frame
    bus_xfer(1'b1, 32'h3000, 32'h41, 5, rd, cyc, ok);
    check("t1_wr_ok", 32'(ok), 1);
    fork
      tx_mon(0, 1, 8'h41);
      begin
        repeat (50) @(negedge clk);
        bus_xfer(1'b0, 32'h3000, 0, 5, rd, cyc, ok);
        check("t1_status_busy", rd, 32'h4);
      end
    join
    bus_xfer(1'b0, 32'h3000, 0, 5, rd, cyc, ok);
    check("t1_status_idle", rd, 32'h6);

    // FIFO_DEPTH+1 writes accepted, next stalls for a frame, frames gap-free
    fork
      tx_mon(0, 6, 8'h10);
      begin
        for (int i = 0; i < 6; i++) begin
          bus_xfer(1'b1, 32'h3000, 32'h10 + 32'(i), 300, rd, cyc, ok);
          if (i < 5) begin
            check($sformatf("t2_wr%0d_cyc", i), 32'(cyc), 0);
          end else begin
            check("t2_wr5_ok", 32'(ok), 1);
            check("t2_wr5_stall", 32'(cyc >= 150 && cyc <= 160), 1);
          end
          if (i == 4) begin
            bus_xfer(1'b0, 32'h3000, 0, 5, rd, cyc, ok);
            check("t2_status_full", rd, 32'h5);
          end
        end
      end
    join

    // RX blocking read on channel 1
    bus_xfer(1'b0, 32'h300C, 0, 3, rd, cyc, ok);
    check("t3_empty_stall", 32'(ok), 0);
    fork
      send_rx(1, 8'h5A, 1'b1);
      begin
        bus_xfer(1'b0, 32'h300C, 0, 200, rd, cyc, ok);
        check("t3_rd_ok", 32'(ok), 1);
        check("t3_rd_data", rd, 32'h5A);
        check("t3_rd_latency", 32'(cyc >= 150 && cyc <= 158), 1);
      end
    join
    bus_xfer(1'b0, 32'h3008, 0, 5, rd, cyc, ok);
    check("t3_status_ch1", rd, 32'h6);

    // overrun
    for (int i = 0; i < 5; i++) send_rx(0, 8'hA0 + 8'(i), 1'b1);
    repeat (4) @(negedge clk);
    bus_xfer(1'b0, 32'h3000, 0, 5, rd, cyc, ok);
    check("t4_status_ovr", rd, 32'h40A);
    for (int i = 0; i < 4; i++) begin
      bus_xfer(1'b0, 32'h3004, 0, 5, rd, cyc, ok);
      check($sformatf("t4_rd%0d", i), rd, 32'hA0 + 32'(i));
    end
    bus_xfer(1'b0, 32'h3000, 0, 5, rd, cyc, ok);
    check("t4_status_clr", rd, 32'h6);

    // framing error, then glitch reject
    send_rx(0, 8'h33, 1'b0);
    repeat (4) @(negedge clk);
    bus_xfer(1'b0, 32'h3000, 0, 5, rd, cyc, ok);
    check("t5_status_fe", rd, 32'h16);
    bus_xfer(1'b0, 32'h3000, 0, 5, rd, cyc, ok);
    check("t5_status_fe_clr", rd, 32'h6);
    rx[0] = 1'b0;
    repeat (8) @(negedge clk);
    rx[0] = 1'b1;
    repeat (200) @(negedge clk);
    bus_xfer(1'b0, 32'h3000, 0, 5, rd, cyc, ok);
    check("t5_glitch_status", rd, 32'h6);

`ifdef TTY_IRQ_EN
    check("irq_idle", 32'(irq), 0);
    send_rx(0, 8'h77, 1'b1);
    repeat (3) @(negedge clk);
    check("irq_set", 32'(irq), 1);
    bus_xfer(1'b0, 32'h3004, 0, 5, rd, cyc, ok);
    check("irq_rd", rd, 32'h77);
    repeat (2) @(negedge clk);
    check("irq_clr", 32'(irq), 0);
`endif

    // reset mid-frame
    bus_xfer(1'b1, 32'h3000, 32'h55, 5, rd, cyc, ok);
    repeat (40) @(negedge clk);
    check("t6_tx_in_frame", 32'(tx[0]), 0);
    #2;
    rstb = 1'b0;
    #1;
    check("t6_tx_async", 32'(tx), 32'h3);
    repeat (3) @(negedge clk);
    rstb = 1'b1;
    @(negedge clk);
    bus_xfer(1'b0, 32'h3000, 0, 5, rd, cyc, ok);
    check("t6_status", rd, 32'h6);
    repeat (200) @(negedge clk);
    check("t6_tx_quiet", 32'(tx), 32'h3);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
